seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 16, meaning width of the scanned word.
REQ-002 SHALL have parameter CLR_CYC, default 2, meaning detector-clear cycles per pattern.
REQ-003 SHALL have parameter DRAIN_CYC, default 2, meaning post-shift cycles still sampling the detector output.
REQ-004 Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to scan; accepted only in IDLE.
- data_word  in  WORD_W  word to scan; captured on accepted start.
- pat_mask  in  4  bit i enables pattern select i; captured on accepted start.
- busy  out  1  high from the cycle after accept until DONE is left.
- done  out  1  one-cycle pulse when all results are valid.
- det_reset  out  1  drives the shared detector reset.
- det_input_seq  out  1  serial bit to the detector.
- det_lookfor_seq  out  2  pattern select to the detector.
- det_seq_detected  in  1  detector match output.
- match_count  out  4*5  per-pattern match counts; field i = bits [5i+4:5i].
- match_flags  out  4  bit i = (field i != 0).

Function
REQ-005 SHALL implement states IDLE, CLR, SHIFT, DRAIN, NEXT, DONE.
REQ-006 IDLE with start=1: SHALL capture data_word and pat_mask, clear all counts and flags, set pattern index p to the lowest enabled index, go to CLR. With captured mask 0, SHALL go directly to DONE.
REQ-007 CLR: det_reset=1 and det_lookfor_seq=p for exactly CLR_CYC cycles, then SHIFT.
REQ-008 SHIFT: exactly WORD_W cycles; det_input_seq = captured word, MSB first, one bit per cycle; det_reset=0.
REQ-009 DRAIN: DRAIN_CYC cycles, det_input_seq=0, det_reset=0.
REQ-010 During SHIFT and DRAIN only: each cycle with det_seq_detected=1 SHALL increment field p by 1, saturating at 31. Samples in CLR, NEXT, IDLE, and DONE SHALL be ignored.
REQ-011 NEXT: one cycle. SHALL set p to the next higher enabled index and go to CLR; if none remains, go to DONE.
REQ-012 DONE: done=1 for one cycle, then IDLE. busy is 0 in IDLE only.
REQ-013 Disabled patterns SHALL report count 0 and flag 0.
REQ-014 det_lookfor_seq SHALL hold p in every non-IDLE state and 0 in IDLE. det_reset SHALL be 1 in IDLE, DONE, and CLR.
REQ-015 start while not IDLE SHALL be ignored and SHALL NOT alter the captured word, mask, or counts.
REQ-016 match_count and match_flags SHALL hold their values from DONE until the next accepted start.
REQ-017 Per-pattern latency SHALL be CLR_CYC+WORD_W+DRAIN_CYC+1 cycles. Total start-to-done latency SHALL be 1 + the sum over enabled patterns of that figure, i.e. 21*n+1 for n enabled patterns at the defaults; mask 0 gives 1 cycle.
REQ-018 Bit counter SHALL be ceil(log2(WORD_W+1)) bits and SHALL reset to 0 on entering SHIFT and on entering DRAIN.

Reset
REQ-019 reset=1 at any clock edge SHALL force IDLE and clear the captured word, captured mask, p, all counts, and flags to 0. It SHALL set busy=0, done=0, det_reset=1, det_input_seq=0, det_lookfor_seq=0.
REQ-020 reset mid-scan SHALL abort with no done pulse. A start in the first cycle after reset is released SHALL be accepted.

Structure
REQ-021 State encoding, the 2-bit pattern-select constants PAT_0..PAT_3, and the count width 5 SHALL live in shared package seq_pkg.
REQ-022 One sub-module SHALL exist: seq_ser_shift, a WORD_W shift register with load and shift enable, MSB out. All other logic SHALL be in seq_scan_ctrl.

Verification
REQ-023 Mask 4'b1111, word 16'hA5C3, bench model pulses det_seq_detected once per pattern in SHIFT -> done at cycle 85 after start, counts {1,1,1,1}, flags 4'b1111, det_input_seq sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
REQ-024 Mask 4'b0101, det_seq_detected held high throughout -> only p=0 then p=2 visited, each count 18, fields 1 and 3 = 0, done at cycle 43.
REQ-025 Mask 4'b0000, start -> done pulse the cycle after start, all counts 0, no CLR state entered.
REQ-026 det_seq_detected high only during CLR and NEXT for mask 4'b0001 -> count 0, flag 0.
REQ-027 Reset asserted in SHIFT of p=1, then start with mask 4'b1000 -> no done for the aborted scan, new scan visits only p=3, earlier counts cleared.
REQ-028 start re-asserted every cycle while busy, with data_word changing -> single done pulse, serialized bits match the first captured word.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-scan controller: FSM state encoding,
// detector pattern-select codes, per-pattern count width and a helper that
// finds the next enabled pattern in a 4-bit mask.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] PAT_0 = 2'd0;
    localparam logic [1:0] PAT_1 = 2'd1;
    localparam logic [1:0] PAT_2 = 2'd2;
    localparam logic [1:0] PAT_3 = 2'd3;

    localparam int NUM_PAT = 4;
    localparam int CNT_W   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Lowest enabled pattern index at or above 'lo'.
    // Result is {found, index}; index is PAT_0 when nothing is found.
    function automatic logic [2:0] find_en(input logic [3:0] mask, input logic [2:0] lo);
        logic [2:0] res;
        res = {1'b0, PAT_0};
        for (int i = NUM_PAT - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(lo))) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_ser_shift.sv
// Parallel-load shift register that presents its word MSB first.
// Load has priority over shift; shifting fills zeros from the bottom.
module seq_ser_shift #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift_en,
    input  logic [WORD_W-1:0] load_word,
    output logic              msb
);

    logic [WORD_W-1:0] sr;

    // Shift register: clear on reset, reload on load, move left on shift_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_word;
        end else if (shift_en) begin
            sr <= {sr[WORD_W-2:0], 1'b0};
        end
    end

    assign msb = sr[WORD_W-1];

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: for every pattern enabled in the captured mask it clears
// the external detector, streams the captured word through it MSB first,
// keeps sampling a few drain cycles, and counts detector hits per pattern.
// Handshake: start is taken only in IDLE; done is a one-cycle pulse after
// which match_count/match_flags stay stable until the next accepted start.
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int CLR_CYC   = 2,
    parameter int DRAIN_CYC = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WORD_W-1:0]          data_word,
    input  logic [3:0]                 pat_mask,
    output logic                       busy,
    output logic                       done,
    output logic                       det_reset,
    output logic                       det_input_seq,
    output logic [1:0]                 det_lookfor_seq,
    input  logic                       det_seq_detected,
    output logic [NUM_PAT*CNT_W-1:0]   match_count,
    output logic [NUM_PAT-1:0]         match_flags
);

    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam logic [BIT_W-1:0] CLR_LAST   = BIT_W'(CLR_CYC - 1);
    localparam logic [BIT_W-1:0] SHIFT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0] DRAIN_LAST = BIT_W'(DRAIN_CYC - 1);

    state_t                         state;
    state_t                         state_next;
    logic [BIT_W-1:0]               cnt;
    logic [WORD_W-1:0]              cword;
    logic [3:0]                     cmask;
    logic [1:0]                     p;
    logic [NUM_PAT-1:0][CNT_W-1:0]  counts;
    logic                           accept;
    logic                           sampling;
    logic                           shift_msb;
    logic [2:0]                     first_hit;
    logic [2:0]                     next_hit;

    assign first_hit = find_en(pat_mask, 3'd0);
    assign next_hit  = find_en(cmask, {1'b0, p} + 3'd1);
    assign sampling  = (state == ST_SHIFT) || (state == ST_DRAIN);

    // The shifter is reloaded during every CLR so each pattern sees the full word.
    seq_ser_shift #(
        .WORD_W (WORD_W)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (state == ST_CLR),
        .shift_en  (state == ST_SHIFT),
        .load_word (cword),
        .msb       (shift_msb)
    );

    // Next-state and Moore outputs; defaults describe the SHIFT/DRAIN/NEXT case.
    always_comb begin
        state_next      = state;
        accept          = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        det_reset       = 1'b0;
        det_input_seq   = 1'b0;
        det_lookfor_seq = p;
        case (state)
            ST_IDLE: begin
                busy            = 1'b0;
                det_reset       = 1'b1;
                det_lookfor_seq = PAT_0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = first_hit[2] ? ST_CLR : ST_DONE;
                end
            end
            ST_CLR: begin
                det_reset = 1'b1;
                if (cnt == CLR_LAST) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                det_input_seq = shift_msb;
                if (cnt == SHIFT_LAST) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt == DRAIN_LAST) state_next = ST_NEXT;
            end
            ST_NEXT: begin
                state_next = next_hit[2] ? ST_CLR : ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                det_reset  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, phase counter, captured request, pattern index and hit counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            cword  <= '0;
            cmask  <= '0;
            p      <= PAT_0;
            counts <= '0;
        end else begin
            state <= state_next;
            // The counter restarts at every phase change and rests at 0 in IDLE.
            if ((state_next != state) || (state == ST_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + BIT_W'(1);
            end
            if (accept) begin
                cword  <= data_word;
                cmask  <= pat_mask;
                p      <= first_hit[1:0];
                counts <= '0;
            end else begin
                if ((state == ST_NEXT) && next_hit[2]) begin
                    p <= next_hit[1:0];
                end
                if (sampling && det_seq_detected && (counts[p] != CNT_MAX)) begin
                    counts[p] <= counts[p] + CNT_W'(1);
                end
            end
        end
    end

    assign match_count = counts;

    // A pattern is flagged whenever its count is non-zero.
    always_comb begin
        match_flags = '0;
        for (int i = 0; i < NUM_PAT; i++) begin
            match_flags[i] = |counts[i];
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl. A driver issues scans with randomized words,
// masks and detector-drive patterns; for each scan it derives from the
// timing rules (per-pattern CLR/SHIFT/DRAIN/NEXT windows) the expected
// per-cycle outputs and the final counts and queues them. A monitor pops
// per-cycle expectations every cycle and pops results whenever done rises.
module tb_seq_scan_ctrl;

    localparam int WORD_W    = 16;
    localparam int CLR_CYC   = 2;
    localparam int DRAIN_CYC = 2;
    localparam int PER       = CLR_CYC + WORD_W + DRAIN_CYC + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] data_word;
    logic [3:0]  pat_mask;
    logic        busy;
    logic        done;
    logic        det_reset;
    logic        det_input_seq;
    logic [1:0]  det_lookfor_seq;
    logic        det_seq_detected;
    logic [19:0] match_count;
    logic [3:0]  match_flags;

    seq_scan_ctrl #(
        .WORD_W    (WORD_W),
        .CLR_CYC   (CLR_CYC),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .data_word        (data_word),
        .pat_mask         (pat_mask),
        .busy             (busy),
        .done             (done),
        .det_reset        (det_reset),
        .det_input_seq    (det_input_seq),
        .det_lookfor_seq  (det_lookfor_seq),
        .det_seq_detected (det_seq_detected),
        .match_count      (match_count),
        .match_flags      (match_flags)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rst;
        logic        chk_rst;
        logic        bit_o;
        logic [1:0]  look;
        logic        chk_cnt;
        logic [19:0] cnt;
        logic [3:0]  flg;
    } cyc_t;

    cyc_t        cyc_q[$];
    logic [23:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    logic [19:0] last_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] flags_of(input logic [19:0] c);
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = (c[5*i +: 5] != 5'd0);
        return f;
    endfunction

    // Phase of offset o (1..PER) inside one pattern window: 0 CLR, 1 SHIFT, 2 DRAIN, 3 NEXT.
    function automatic int phase_of(input int o);
        if (o <= CLR_CYC) return 0;
        if (o <= CLR_CYC + WORD_W) return 1;
        if (o <= CLR_CYC + WORD_W + DRAIN_CYC) return 2;
        return 3;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc_t        e;
        logic [23:0] r;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("busy", 32'(busy), 32'(e.busy));
            check("done", 32'(done), 32'(e.done));
            check("det_input_seq", 32'(det_input_seq), 32'(e.bit_o));
            check("det_lookfor_seq", 32'(det_lookfor_seq), 32'(e.look));
            if (e.chk_rst) check("det_reset", 32'(det_reset), 32'(e.rst));
            if (e.chk_cnt) begin
                check("hold_count", 32'(match_count), 32'(e.cnt));
                check("hold_flags", 32'(match_flags), 32'(e.flg));
            end
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_extra: done=1 with no scan outstanding at t=%0t", $time);
            end else begin
                r = exp_q.pop_front();
                check("result_count", 32'(match_count), 32'(r[19:0]));
                check("result_flags", 32'(match_flags), 32'(r[23:20]));
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1 of an IDLE cycle (cycle 0 of the scan).
    // mode: 0 random detector, 1 always high, 2 high only in CLR/NEXT,
    // 3 one pulse per pattern somewhere in SHIFT.
    task automatic do_scan(input logic [15:0] word, input logic [3:0] mask,
                           input int mode, input bit spam, input int abort_at);
        int          en[$];
        int          n, lat, m, o, ph, pp, last_k;
        int          pulse_off[4];
        logic        drv[0:127];
        int          c[4];
        logic [19:0] rc;
        cyc_t        e;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) en.push_back(i);
            c[i] = 0;
            pulse_off[i] = $urandom_range(CLR_CYC + 1, CLR_CYC + WORD_W);
        end
        n   = en.size();
        lat = PER * n + 1;
        // cycle 0: IDLE, previous results still held
        e = '{busy: 1'b0, done: 1'b0, rst: 1'b1, chk_rst: 1'b1, bit_o: 1'b0,
              look: 2'd0, chk_cnt: 1'b1, cnt: last_cnt, flg: flags_of(last_cnt)};
        cyc_q.push_back(e);
        last_k = (abort_at > 0) ? abort_at : lat;
        for (int k = 1; k <= lat; k++) begin
            e = '0;
            e.busy = 1'b1;
            drv[k] = 1'b0;
            if (k < lat) begin
                m  = (k - 1) / PER;
                o  = (k - 1) % PER + 1;
                ph = phase_of(o);
                pp = en[m];
                case (mode)
                    0: drv[k] = 1'($urandom_range(0, 1));
                    1: drv[k] = 1'b1;
                    2: drv[k] = (ph == 0) || (ph == 3);
                    default: drv[k] = (o == pulse_off[m]);
                endcase
                if ((ph == 1 || ph == 2) && drv[k] && c[pp] < 31) c[pp]++;
                e.look    = 2'(pp);
                e.rst     = (ph == 0);
                e.chk_rst = (ph != 3);
                e.bit_o   = (ph == 1) ? word[WORD_W - 1 - (o - CLR_CYC - 1)] : 1'b0;
            end else begin
                if (mode == 1) drv[k] = 1'b1;
                e.done    = 1'b1;
                e.rst     = 1'b1;
                e.chk_rst = 1'b1;
                e.look    = (n > 0) ? 2'(en[n-1]) : 2'd0;
            end
            if (k <= last_k) cyc_q.push_back(e);
        end
        for (int i = 0; i < 4; i++) rc[5*i +: 5] = 5'(c[i]);
        if (abort_at == 0) begin
            exp_q.push_back({flags_of(rc), rc});
            last_cnt = rc;
        end else begin
            last_cnt = '0;
        end
        start            = 1'b1;
        data_word        = word;
        pat_mask         = mask;
        det_seq_detected = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            det_seq_detected = drv[k];
            start            = spam;
            data_word        = 16'($urandom);
            pat_mask         = spam ? 4'($urandom) : mask;
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset            = 1'b0;
                start            = 1'b0;
                det_seq_detected = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        start            = 1'b0;
        det_seq_detected = 1'b0;
    endtask

    // ---------------- reset, stimulus and report ----------------
    initial begin
        n_cmp            = 0;
        n_err            = 0;
        last_cnt         = '0;
        reset            = 1'b1;
        start            = 1'b0;
        data_word        = '0;
        pat_mask         = '0;
        det_seq_detected = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_det_reset", 32'(det_reset), 32'd1);
            check("rst_det_input_seq", 32'(det_input_seq), 32'd0);
            check("rst_det_lookfor_seq", 32'(det_lookfor_seq), 32'd0);
            check("rst_match_count", 32'(match_count), 32'd0);
            check("rst_match_flags", 32'(match_flags), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        // start in the very first cycle after reset release
        do_scan(16'hA5C3, 4'b1111, 3, 1'b0, 0);
        do_scan(16'($urandom), 4'b0101, 1, 1'b0, 0);
        do_scan(16'($urandom), 4'b0000, 0, 1'b0, 0);
        do_scan(16'($urandom), 4'b0001, 2, 1'b0, 0);
        do_scan(16'($urandom), 4'b0110, 0, 1'b1, 0);
        // abort inside SHIFT of pattern 1, then restart right after release
        do_scan(16'($urandom), 4'b1111, 0, 1'b0, PER + CLR_CYC + 8);
        do_scan(16'($urandom), 4'b1000, 1, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            do_scan(16'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        repeat (5) @(negedge clk);
        check("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
        check("result_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
